// File: rtl/pipe_field.sv
// pipe_field: two scrolling pipe obstacles with LFSR-chosen gap heights, scoring and a registered pixel hit.
// Optional PIPE_SPEEDUP_EN: scroll step becomes SCROLL_STEP + (score>>3), capped at 2*SCROLL_STEP.
module pipe_field #(
   parameter int         SCREEN_W     = 640,
   parameter int         SCREEN_H     = 480,
   parameter int         PIPE_W       = 60,
   parameter int         GAP_H        = 120,
   parameter int         GAP_MIN      = 40,
   parameter int         PIPE_SPACING = 320,
   parameter int         SCROLL_STEP  = 2,
   parameter int         BIRD_X       = 160,
   parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       game_run,
   input  logic       game_restart,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic       pixel_active,
   output logic       pipe_color,
   output logic       score_tick,
   output logic [7:0] score
);

   localparam logic signed [11:0] X0_INIT   = 12'(SCREEN_W);
   localparam logic signed [11:0] X1_INIT   = 12'(SCREEN_W + PIPE_SPACING);
   localparam logic signed [11:0] PW        = 12'(PIPE_W);
   localparam logic signed [11:0] GH        = 12'(GAP_H);
   localparam logic signed [11:0] SPACING   = 12'(PIPE_SPACING);
   localparam logic signed [11:0] BX        = 12'(BIRD_X);
   localparam logic signed [11:0] STEP_BASE = 12'(SCROLL_STEP);
   localparam logic [8:0]         GAP_BASE  = 9'(GAP_MIN);
   localparam logic [8:0]         GAP_INIT  = 9'(GAP_MIN + 80);

   // The lowest possible gap must still fit on screen, and the seed must keep the LFSR alive.
   if ((GAP_MIN + 255 + GAP_H > SCREEN_H) || (PIPE_SPACING <= SCROLL_STEP) || (LFSR_SEED == 8'h00)) begin : g_bad_cfg
      $error("pipe_field: invalid parameter set");
   end

   logic signed [11:0] x0, x1, step, nx0, nx1, px, py;
   logic [8:0]         gap0, gap1;
   logic [7:0]         lfsr, lfsr_next;
   logic               respawn0, respawn1, pass, hit0, hit1;

   function automatic logic on_pipe(input logic signed [11:0] x, input logic [8:0] gap,
                                    input logic signed [11:0] col, input logic signed [11:0] row);
      logic signed [11:0] top;
      top = $signed({3'b000, gap});
      return (col >= x) && (col < x + PW) && ((row < top) || (row >= top + GH));
   endfunction

`ifdef PIPE_SPEEDUP_EN
   logic signed [11:0] boost;
   always_comb begin
      boost = $signed({7'b0000000, score[7:3]});
      step  = (boost >= STEP_BASE) ? (STEP_BASE <<< 1) : (STEP_BASE + boost);
   end
`else
   assign step = STEP_BASE;
`endif

   always_comb begin
      nx0       = x0 - step;
      nx1       = x1 - step;
      respawn0  = (nx0 <= -PW);
      respawn1  = (nx1 <= -PW);
      pass      = ((x0 + PW > BX) && (nx0 + PW <= BX)) || ((x1 + PW > BX) && (nx1 + PW <= BX));
      lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      px        = $signed({2'b00, pixel_x});
      py        = $signed({2'b00, pixel_y});
      hit0      = on_pipe(x0, gap0, px, py);
      hit1      = on_pipe(x1, gap1, px, py);
   end

   // A respawning pipe is placed relative to the other pipe's already-scrolled position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x0         <= X0_INIT;
         x1         <= X1_INIT;
         gap0       <= GAP_INIT;
         gap1       <= GAP_INIT;
         lfsr       <= LFSR_SEED;
         score      <= 8'd0;
         score_tick <= 1'b0;
         pipe_color <= 1'b0;
      end else if (game_restart) begin
         x0         <= X0_INIT;
         x1         <= X1_INIT;
         gap0       <= GAP_INIT;
         gap1       <= GAP_INIT;
         lfsr       <= LFSR_SEED;
         score      <= 8'd0;
         score_tick <= 1'b0;
         pipe_color <= 1'b0;
      end else begin
         score_tick <= 1'b0;
         pipe_color <= pixel_active & (hit0 | hit1);
         if (frame_tick && game_run) begin
            lfsr <= lfsr_next;
            if (respawn0) begin
               x0   <= nx1 + SPACING;
               gap0 <= GAP_BASE + {1'b0, lfsr};
            end else begin
               x0 <= nx0;
            end
            if (respawn1) begin
               x1   <= nx0 + SPACING;
               gap1 <= GAP_BASE + {1'b0, lfsr};
            end else begin
               x1 <= nx1;
            end
            if (pass) begin
               score_tick <= 1'b1;
               if (score != 8'hFF) begin
                  score <= score + 8'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_field.sv
// Self-checking bench for pipe_field: pixel probes go through an expected-value queue, ticks against a reference model.
module tb_pipe_field;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_tick, game_run, game_restart, pixel_active;
   logic [9:0] pixel_x, pixel_y;
   logic       pipe_color, score_tick;
   logic [7:0] score;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int    px;
      int    py;
      bit    act;
      bit    exp;
      string name;
   } vec_t;

   vec_t  vecs[$];
   bit    exp_q[$];
   string name_q[$];

   int       mx0, mx1, mgap0, mgap1, mscore;
   bit [7:0] mlfsr;

   pipe_field dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_run(game_run),
      .game_restart(game_restart), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pixel_active(pixel_active), .pipe_color(pipe_color),
      .score_tick(score_tick), .score(score)
   );

   always #5 clk = ~clk;

   // Reference model of the pipe field, written from the behavioural description.
   function automatic void model_reset();
      mx0 = 640; mx1 = 960; mgap0 = 120; mgap1 = 120; mscore = 0; mlfsr = 8'hA5;
   endfunction

   function automatic bit model_tick();
      int  st, n0, n1;
      bit  p;
      st = 2;
`ifdef PIPE_SPEEDUP_EN
      st = 2 + (mscore >> 3);
      if (st > 4) st = 4;
`endif
      n0 = mx0 - st;
      n1 = mx1 - st;
      p  = ((mx0 + 60 > 160) && (n0 + 60 <= 160)) || ((mx1 + 60 > 160) && (n1 + 60 <= 160));
      if (n0 <= -60) begin mx0 = n1 + 320; mgap0 = 40 + int'(mlfsr); end else mx0 = n0;
      if (n1 <= -60) begin mx1 = n0 + 320; mgap1 = 40 + int'(mlfsr); end else mx1 = n1;
      mlfsr = {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
      if (p && mscore < 255) mscore++;
      return p;
   endfunction

   function automatic bit model_color(input int px, input int py, input bit act);
      bit h0, h1;
      h0 = (px >= mx0) && (px < mx0 + 60) && ((py < mgap0) || (py >= mgap0 + 120));
      h1 = (px >= mx1) && (px < mx1 + 60) && ((py < mgap1) || (py >= mgap1 + 120));
      return act && (h0 || h1);
   endfunction

   task automatic check_val(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic checkOutput();
      bit    e;
      string n;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      end else begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         check_val(n, int'(pipe_color), int'(e));
      end
   endtask

   task automatic applyStimulus(input int px, input int py, input bit act, input bit exp, input string nm);
      @(negedge clk);
      pixel_x      = 10'(px);
      pixel_y      = 10'(py);
      pixel_active = act;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(posedge clk);
      #1 checkOutput();
   endtask

   task automatic doTick(input bit run, input bit restart);
      bit exp_tick;
      @(negedge clk);
      frame_tick   = 1'b1;
      game_run     = run;
      game_restart = restart;
      if (restart) begin
         model_reset();
         exp_tick = 1'b0;
      end else if (run) begin
         exp_tick = model_tick();
      end else begin
         exp_tick = 1'b0;
      end
      @(posedge clk);
      #1;
      check_val("score_tick", int'(score_tick), int'(exp_tick));
      check_val("score", int'(score), mscore);
      @(negedge clk);
      frame_tick   = 1'b0;
      game_restart = 1'b0;
   endtask

   task automatic addVec(input int px, input int py, input bit act, input bit exp, input string nm);
      vec_t v;
      v.px = px; v.py = py; v.act = act; v.exp = exp; v.name = nm;
      vecs.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int ox;
      int guard;

      // Pipe 0 sits at x=638..697 and pipe 1 at x=958..1017 after one tick; both gaps span rows 120..239.
      addVec(640,  10, 1'b1, 1'b1, "x640_y10");
      addVec(640, 150, 1'b1, 1'b0, "x640_in_gap");
      addVec(700,  10, 1'b1, 1'b0, "x700_right");
      addVec(638,  10, 1'b1, 1'b1, "left_edge");
      addVec(637,  10, 1'b1, 1'b0, "left_of_edge");
      addVec(697,  10, 1'b1, 1'b1, "right_edge");
      addVec(698,  10, 1'b1, 1'b0, "past_right_edge");
      addVec(640,  10, 1'b0, 1'b0, "inactive");
      addVec(640, 119, 1'b1, 1'b1, "above_gap");
      addVec(640, 120, 1'b1, 1'b0, "gap_top_row");
      addVec(640, 239, 1'b1, 1'b0, "gap_bottom_row");
      addVec(640, 240, 1'b1, 1'b1, "below_gap");
      addVec(958,  10, 1'b1, 1'b1, "pipe1_left_edge");
      addVec(957,  10, 1'b1, 1'b0, "pipe1_left_of_edge");

      rst = 1'b1; frame_tick = 1'b0; game_run = 1'b0; game_restart = 1'b0;
      pixel_x = 10'd0; pixel_y = 10'd0; pixel_active = 1'b0;
      model_reset();

      $display("[TB] reset state");
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_pipe_color", int'(pipe_color), 0);
      check_val("rst_score", int'(score), 0);
      check_val("rst_score_tick", int'(score_tick), 0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(640, 10, 1'b1, 1'b1, "rst_x640");
      applyStimulus(639, 10, 1'b1, 1'b0, "rst_x639");
      applyStimulus(960, 10, 1'b1, 1'b1, "rst_x960");

      $display("[TB] scroll and draw");
      doTick(1'b1, 1'b0);
      foreach (vecs[i]) applyStimulus(vecs[i].px, vecs[i].py, vecs[i].act, vecs[i].exp, vecs[i].name);

      $display("[TB] scoring at tick 270");
      for (int t = 2; t <= 270; t++) doTick(1'b1, 1'b0);
      check_val("score_after_270", int'(score), 1);
      applyStimulus(100, 0, 1'b1, 1'b1, "x0_at_100");
      applyStimulus( 99, 0, 1'b1, 1'b0, "left_of_100");

      $display("[TB] respawn at tick 350");
      for (int t = 271; t <= 350; t++) doTick(1'b1, 1'b0);
      applyStimulus(580, 0, 1'b1, 1'b1, "respawn_x580");
      applyStimulus(579, 0, 1'b1, 1'b0, "respawn_left");
      applyStimulus(639, 0, 1'b1, 1'b1, "respawn_right_edge");
      applyStimulus(640, 0, 1'b1, 1'b0, "respawn_past_right");
      applyStimulus(580, mgap0 - 1,   1'b1, model_color(580, mgap0 - 1, 1'b1),   "respawn_above_gap");
      applyStimulus(580, mgap0,       1'b1, model_color(580, mgap0, 1'b1),       "respawn_gap_top");
      applyStimulus(580, mgap0 + 119, 1'b1, model_color(580, mgap0 + 119, 1'b1), "respawn_gap_bottom");
      applyStimulus(580, mgap0 + 120, 1'b1, model_color(580, mgap0 + 120, 1'b1), "respawn_below_gap");
      applyStimulus(260, 0, 1'b1, 1'b1, "pipe1_at_260");

      $display("[TB] freeze and restart");
      for (int t = 0; t < 10; t++) doTick(1'b0, 1'b0);
      applyStimulus(580, 0, 1'b1, 1'b1, "frozen_x580");
      applyStimulus(579, 0, 1'b1, 1'b0, "frozen_left");
      doTick(1'b1, 1'b1);
      applyStimulus(640, 10, 1'b1, 1'b1, "restart_x640");
      applyStimulus(639, 10, 1'b1, 1'b0, "restart_x639");
      applyStimulus(960, 10, 1'b1, 1'b1, "restart_x960");

      $display("[TB] async reset mid-cycle");
      for (int t = 1; t <= 270; t++) doTick(1'b1, 1'b0);
      applyStimulus(100, 0, 1'b1, 1'b1, "pre_rst_x100");
      #2 rst = 1'b1;
      #1;
      check_val("async_pipe_color", int'(pipe_color), 0);
      check_val("async_score", int'(score), 0);
      check_val("async_score_tick", int'(score_tick), 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      applyStimulus(100, 0, 1'b1, 1'b0, "post_rst_x100");
      applyStimulus(640, 0, 1'b1, 1'b1, "post_rst_x640");

`ifdef PIPE_SPEEDUP_EN
      $display("[TB] speedup at score 8");
      guard = 0;
      while (mscore < 8 && guard < 3000) begin
         doTick(1'b1, 1'b0);
         guard++;
      end
      check_val("score_reached_8", int'(score), 8);
      ox = (mx0 >= 4 && mx0 <= 960) ? mx0 : mx1;
      doTick(1'b1, 1'b0);
      applyStimulus(ox - 3, 0, 1'b1, 1'b1, "speedup_new_edge");
      applyStimulus(ox - 4, 0, 1'b1, 1'b0, "speedup_left_of_edge");
`else
      ox = 0;
      guard = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
